nn_layer_sequencer: RTL and testbench

Time-multiplexed controller for one 4-input, 4-neuron perceptron layer. It evaluates all neurons through a single shared signed multiply-accumulate path instead of four parallel perceptrons. It owns a byte-serial parameter loader with a valid/ready handshake and a start/busy/done sequencer. It sits between the ui_in byte stream and the network output register.

---
 rtl/nn_layer_sequencer.sv | 139 +++++++++++++
 tb/tb_nn_layer_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Time-multiplexed 4x4 perceptron layer: byte-serial parameter loader plus a
// shared signed MAC sequenced over 6 cycles per neuron.
module nn_layer_sequencer #(
  parameter int DATA_W    = 8,
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4,
  parameter int ACC_W     = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [DATA_W-1:0]             load_data,
  output logic                          load_ready,
  input  logic                          start,
  input  logic [N_INPUTS*DATA_W-1:0]    x_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  output logic [N_NEURONS*DATA_W-1:0]   out_flat,
  output logic                          params_loaded
);

  localparam int N_BYTES = N_NEURONS * (N_INPUTS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               cnt;
  logic [DATA_W-1:0]        param_mem [0:N_BYTES-1];
  logic [N_INPUTS*DATA_W-1:0] x_q;
  logic signed [ACC_W-1:0]  acc;
  logic [1:0]               neuron;
  logic [2:0]               step;

  logic                     beat, start_ok, last_write;
  logic [1:0]               mac_i;
  logic [4:0]               base, w_addr, b_addr;
  logic [DATA_W-1:0]        w_sel, b_sel, x_sel;
  logic signed [15:0]       prod;
  logic [DATA_W-1:0]        act;

  // Step 1..4 maps onto MAC input 0..3 through 2-bit wraparound (4 -> 3).
  assign mac_i  = step[1:0] - 2'd1;
  assign base   = {1'b0, neuron, 2'b00} + {3'b000, neuron};
  assign w_addr = base + {3'b000, mac_i};
  assign b_addr = base + 5'd4;
  assign w_sel  = param_mem[w_addr];
  assign b_sel  = param_mem[b_addr];
  assign x_sel  = x_q[{mac_i, 3'b000} +: 8];
  assign prod   = $signed(w_sel) * $signed(x_sel);

  always_comb begin
    act = acc[7:0];
    if (acc <= 0)
      act = 8'd0;
    else if (acc >= 127)
      act = 8'd127;
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    beat       = 1'b0;
    start_ok   = 1'b0;
    last_write = 1'b0;
    case (state_q)
      IDLE: begin
        beat     = load_valid;
        start_ok = start && params_loaded && (cnt == 5'd0) && !load_valid;
        if (start_ok)
          state_d = RUN;
      end
      RUN: begin
        if (step == 3'(N_INPUTS + 1) && neuron == 2'(N_NEURONS - 1)) begin
          last_write = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt           <= 5'd0;
      params_loaded <= 1'b0;
      x_q           <= '0;
      acc           <= '0;
      neuron        <= 2'd0;
      step          <= 3'd0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      out_flat      <= '0;
      for (int k = 0; k < N_BYTES; k++)
        param_mem[k] <= '0;
    end else begin
      state_q <= state_d;
      done    <= last_write;

      if (beat) begin
        param_mem[cnt] <= load_data;
        if (cnt == 5'(N_BYTES - 1)) begin
          cnt           <= 5'd0;
          params_loaded <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end

      if (start_ok) begin
        x_q       <= x_flat;
        out_valid <= 1'b0;
        neuron    <= 2'd0;
        step      <= 3'd0;
      end

      if (state_q == RUN) begin
        if (step == 3'd0) begin
          acc  <= {{(ACC_W-8){b_sel[7]}}, b_sel};
          step <= step + 3'd1;
        end else if (step <= 3'(N_INPUTS)) begin
          acc  <= acc + {{(ACC_W-16){prod[15]}}, prod};
          step <= step + 3'd1;
        end else begin
          out_flat[{neuron, 3'b000} +: 8] <= act;
          step <= 3'd0;
          if (last_write)
            out_valid <= 1'b1;
          else
            neuron <= neuron + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: loads parameter sets, runs the layer
// and compares against hand-computed results.
module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        start;
  logic [31:0] x_flat;
  logic        busy, done, out_valid, params_loaded;
  logic [31:0] out_flat;

  int total = 0;
  int bad   = 0;

  localparam int SET_ID = 0, SET_SAT = 1, SET_CLAMP = 2;

  nn_layer_sequencer dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .x_flat(x_flat), .busy(busy),
    .done(done), .out_valid(out_valid), .out_flat(out_flat),
    .params_loaded(params_loaded)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int set, input int k);
    int n, s;
    n = k / 5;
    s = k % 5;
    case (set)
      SET_ID:  return (s == 4) ? 8'h00 : ((s == n) ? 8'h01 : 8'h00);
      SET_SAT: return 8'h7F;
      default: return (s == 4) ? 8'h80 : 8'h01;
    endcase
  endfunction

  task automatic load_range(input int set, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      load_valid = 1'b1;
      load_data  = pbyte(set, k);
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Accepts a start, then runs 24 edges; optionally pulses start mid-run or
  // holds load_valid high throughout to exercise backpressure.
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] exp,
                     input bit mid_start, input bit hold_load);
    int done_cnt, done_at;
    done_cnt = 0;
    done_at  = -1;
    x_flat = x;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({tag, "_busy_t0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ovalid_t0"}, {31'd0, out_valid}, 32'd0);
    if (hold_load) begin
      load_valid = 1'b1;
      load_data  = 8'h01;
    end
    for (int i = 1; i <= 24; i++) begin
      start = (mid_start && i == 5);
      tick();
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (hold_load && i == 12)
        chk({tag, "_ready_run"}, {31'd0, load_ready}, 32'd0);
    end
    start = 1'b0;
    chk({tag, "_done_cnt"}, done_cnt, 32'd1);
    chk({tag, "_done_at"}, done_at, 32'd24);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out"}, out_flat, exp);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; start = 1'b0; x_flat = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_ploaded", {31'd0, params_loaded}, 32'd0);
    chk("rst_out", out_flat, 32'h0);

    x_flat = 32'h7FFB140A;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_noload", {31'd0, busy}, 32'd0);

    load_range(SET_ID, 0, 6);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_partial", {31'd0, busy}, 32'd0);
    load_range(SET_ID, 7, 18);
    chk("ploaded_pre", {31'd0, params_loaded}, 32'd0);
    load_range(SET_ID, 19, 19);
    chk("ploaded_post", {31'd0, params_loaded}, 32'd1);

    start = 1'b1; load_valid = 1'b1; load_data = pbyte(SET_ID, 0);
    tick();
    start = 1'b0; load_valid = 1'b0;
    chk("start_with_load", {31'd0, busy}, 32'd0);
    load_range(SET_ID, 1, 19);

    run("ident", 32'h7FFB140A, 32'h7F00140A, 1'b1, 1'b0);
    tick();
    chk("ident_done_drop", {31'd0, done}, 32'd0);
    chk("ident_ovalid_hold", {31'd0, out_valid}, 32'd1);

    load_range(SET_SAT, 0, 19);
    run("sat", 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0, 1'b0);

    load_range(SET_CLAMP, 0, 19);
    run("clamp", 32'h0A0A0A0A, 32'h00000000, 1'b0, 1'b1);
    chk("bp_ready_idle", {31'd0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
    load_range(SET_CLAMP, 1, 19);
    run("clamp2", 32'h0A0A0A0A, 32'h00000000, 1'b0, 1'b0);

    load_range(SET_SAT, 0, 19);
    x_flat = 32'h7F7F7F7F;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out", out_flat, 32'h0);
    chk("midrst_ploaded", {31'd0, params_loaded}, 32'd0);
    chk("midrst_ovalid", {31'd0, out_valid}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_after_rst", {31'd0, busy}, 32'd0);
    load_range(SET_ID, 0, 18);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_19beats", {31'd0, busy}, 32'd0);
    load_range(SET_ID, 19, 19);
    run("ident2", 32'h7FFB140A, 32'h7F00140A, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
